// File: rtl/mod_counter_if.sv
`default_nettype none
// ============================================================================
// mod_counter_if : control/status bundle for one mod_counter stage
// Revision 1.0
// ============================================================================
interface mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             cin;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, cin, up_dn, load, load_val, ovf_clr,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, cin, up_dn, load, load_val, ovf_clr,
    output q, tc, wrap, ovf
  );
endinterface
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// mod_counter : synchronous up/down modulo counter with load, wrap/saturate,
//               cascade terminal count and sticky overflow
// Revision 1.0
// ============================================================================
module mod_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  wire logic      clk,
  input  wire logic      reset_outer,
  mod_counter_if.slave   bus
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic             r_ovf;

  logic [WIDTH-1:0] w_q_next;
  logic             w_count;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_end;

  assign w_count  = bus.en & bus.cin;
  assign w_at_top = (r_q == C_MAX);
  assign w_at_bot = (r_q == C_ZERO);
  // An end event only happens on a real count step, never on a load.
  assign w_end    = ~bus.load & w_count & (bus.up_dn ? w_at_top : w_at_bot);

  always_comb begin
    w_q_next = r_q;
    if (bus.load) begin
      w_q_next = (bus.load_val > C_MAX) ? C_MAX : bus.load_val;
    end else if (w_count) begin
      if (bus.up_dn) begin
        if (!w_at_top)     w_q_next = r_q + C_ONE;
        else if (!SATURATE) w_q_next = C_ZERO;
      end else begin
        if (!w_at_bot)     w_q_next = r_q - C_ONE;
        else if (!SATURATE) w_q_next = C_MAX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_outer) begin
    if (!reset_outer) begin
      r_q    <= C_ZERO;
      r_wrap <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_wrap <= w_end;
      // Set has priority over a same-edge clear.
      if (w_end)            r_ovf <= 1'b1;
      else if (bus.ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign bus.q    = r_q;
  assign bus.wrap = r_wrap;
  assign bus.ovf  = r_ovf;
  assign bus.tc   = bus.cin & (bus.up_dn ? w_at_top : w_at_bot);

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// tb_mod_counter : directed scoreboard bench for mod_counter
// Revision 1.0
// ============================================================================
module tb_mod_counter;

  logic clk = 1'b0;
  logic reset_outer;
  always #5 clk = ~clk;

  mod_counter_if #(.WIDTH(4)) bw ();
  mod_counter_if #(.WIDTH(4)) bs ();
  mod_counter_if #(.WIDTH(4)) clo ();
  mod_counter_if #(.WIDTH(4)) chi ();

  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_w
    (.clk(clk), .reset_outer(reset_outer), .bus(bw));
  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) dut_s
    (.clk(clk), .reset_outer(reset_outer), .bus(bs));
  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_lo
    (.clk(clk), .reset_outer(reset_outer), .bus(clo));
  mod_counter #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) dut_hi
    (.clk(clk), .reset_outer(reset_outer), .bus(chi));

  assign chi.cin = clo.tc & clo.en;

  typedef struct {
    string tag;
    int    dut;
    int    q;
    logic  wrap;
    logic  ovf;
    logic  tc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input int dut, input int q,
                      input logic wr, input logic ov, input logic tc);
    exp_t e;
    e.tag = tag; e.dut = dut; e.q = q; e.wrap = wr; e.ovf = ov; e.tc = tc;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.dut)
        0: begin
          cmp({e.tag, ".q"},    32'(bw.q),    32'(e.q));
          cmp({e.tag, ".wrap"}, 32'(bw.wrap), 32'(e.wrap));
          cmp({e.tag, ".ovf"},  32'(bw.ovf),  32'(e.ovf));
          cmp({e.tag, ".tc"},   32'(bw.tc),   32'(e.tc));
        end
        1: begin
          cmp({e.tag, ".q"},    32'(bs.q),    32'(e.q));
          cmp({e.tag, ".wrap"}, 32'(bs.wrap), 32'(e.wrap));
          cmp({e.tag, ".ovf"},  32'(bs.ovf),  32'(e.ovf));
          cmp({e.tag, ".tc"},   32'(bs.tc),   32'(e.tc));
        end
        default: cmp({e.tag, ".hilo"}, 32'({chi.q, clo.q}), 32'(e.q));
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_outer = 1'b0;
    bw.en = 0;  bw.cin = 1;  bw.up_dn = 1;  bw.load = 0;  bw.load_val = 0;  bw.ovf_clr = 0;
    bs.en = 0;  bs.cin = 1;  bs.up_dn = 1;  bs.load = 0;  bs.load_val = 0;  bs.ovf_clr = 0;
    clo.en = 0; clo.cin = 1; clo.up_dn = 1; clo.load = 0; clo.load_val = 0; clo.ovf_clr = 0;
    chi.en = 1; chi.up_dn = 1; chi.load = 0; chi.load_val = 0; chi.ovf_clr = 0;

    // Reset state, then held across an edge
    #2;
    push("rst", 0, 0, 0, 0, 0);
    check_all();
    push("rst_hold", 0, 0, 0, 0, 0);
    step();
    reset_outer = 1'b1;

    // Wrap mode, count up 12 cycles
    bw.en = 1;
    for (int i = 1; i <= 12; i++) begin
      push("up", 0, i % 10, (i == 10), (i >= 10), ((i % 10) == 9));
      step();
    end

    // Load 0 then count down through the wrap
    bw.up_dn = 0; bw.load = 1; bw.load_val = 0;
    push("ld0", 0, 0, 0, 1, 1);
    step();
    bw.load = 0;
    push("dn9", 0, 9, 1, 1, 0); step();
    push("dn8", 0, 8, 0, 1, 0); step();
    push("dn7", 0, 7, 0, 1, 0); step();

    // ovf_clr alongside an end event, then alone
    bw.load = 1; bw.load_val = 0;
    push("ld0b", 0, 0, 0, 1, 1); step();
    bw.load = 0; bw.ovf_clr = 1;
    push("clr_end", 0, 9, 1, 1, 0); step();
    bw.en = 0;
    push("clr_only", 0, 9, 0, 0, 0); step();
    bw.ovf_clr = 0;

    // Clamped load with en=1, then load with en=0
    bw.en = 1; bw.up_dn = 1; bw.load = 1; bw.load_val = 4'd13;
    push("ld13", 0, 9, 0, 0, 1); step();
    bw.en = 0; bw.load_val = 4'd3;
    push("ld3_en0", 0, 3, 0, 0, 0); step();
    bw.load = 0;

    // Saturate mode
    bs.load = 1; bs.load_val = 4'd7;
    push("s_ld7", 1, 7, 0, 0, 0); step();
    bs.load = 0; bs.en = 1;
    push("s_8",  1, 8, 0, 0, 0); step();
    push("s_9",  1, 9, 0, 0, 1); step();
    push("s_9a", 1, 9, 1, 1, 1); step();
    push("s_9b", 1, 9, 1, 1, 1); step();
    bs.load = 1; bs.load_val = 4'd1; bs.up_dn = 0;
    push("s_ld1", 1, 1, 0, 1, 0); step();
    bs.load = 0;
    push("s_0",  1, 0, 0, 1, 1); step();
    push("s_0a", 1, 0, 1, 1, 1); step();
    bs.en = 0;

    // Two-stage BCD cascade
    clo.en = 1;
    for (int k = 1; k <= 23; k++) begin
      push("bcd", 2, (k / 10) * 16 + (k % 10), 0, 0, 0);
      step();
    end
    clo.en = 0;

    // Async reset mid-count with ovf set
    bw.up_dn = 1; bw.load = 1; bw.load_val = 4'd9;
    push("r_ld9", 0, 9, 0, 0, 1); step();
    bw.load = 0; bw.en = 1;
    push("r_wrap", 0, 0, 1, 1, 0); step();
    bw.load = 1; bw.load_val = 4'd6;
    push("r_ld6", 0, 6, 0, 1, 0); step();
    bw.load = 0;
    #2;
    reset_outer = 1'b0;
    #1;
    push("r_async", 0, 0, 0, 0, 0);
    check_all();
    push("r_hold1", 0, 0, 0, 0, 0); step();
    push("r_hold2", 0, 0, 0, 0, 0); step();
    reset_outer = 1'b1;
    push("r_resume", 0, 1, 0, 0, 0); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
# mod_counter

Parametrised synchronous modulo counter that replaces the 4-bit T-flip-flop ripple counter in the lecture designs. All bits switch on one clock edge, so there is no ripple skew. Adds:
- up/down counting
- parallel load
- programmable modulus
- wrap or saturate mode
- a cascade input and terminal-count output for chaining into wider or BCD counters
- a sticky overflow flag

It sits wherever a free-running or divide-by-N count is needed, for example timers and digit counters feeding display logic.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (≥1)
- MAX, 2**WIDTH-1, terminal value; count range is 0..MAX (MAX ≤ 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at the ends, 1 = hold at the ends

Ports:
- clk  in  1  clock; rising edge active
- reset_outer  in  1  asynchronous, active-low reset
- en  in  1  count enable
- cin  in  1  cascade enable; counting requires en & cin; tie to 1 when not chained
- up_dn  in  1  1 = count up, 0 = count down
- load  in  1  synchronous parallel load
- load_val  in  WIDTH  value to load
- ovf_clr  in  1  clears the sticky overflow flag
- q  out  WIDTH  current count (registered)
- tc  out  1  terminal count, combinational
- wrap  out  1  one-cycle registered pulse after an end-of-range event
- ovf  out  1  sticky overflow/underflow flag (registered)

## Operation
- Reset (reset_outer = 0): q = 0, wrap = 0, ovf = 0, taking effect immediately and independent of clk. The counter holds while reset is asserted; the first update is on the first rising edge after release.
- Priority each edge: load > count > hold.
- Load:
  - q ← load_val; if load_val > MAX, q ← MAX.
  - Load ignores en, cin and up_dn.
  - Load never sets wrap or ovf.
- Count (load = 0, en = 1, cin = 1):
  - Up, q < MAX: q ← q+1.
  - Up, q = MAX: q ← 0 if SATURATE = 0, else q holds MAX. This is an end event.
  - Down, q > 0: q ← q−1.
  - Down, q = 0: q ← MAX if SATURATE = 0, else q holds 0. This is an end event.
- Hold: en = 0 or cin = 0 with load = 0 leaves q unchanged.
- tc = cin & (up_dn ? q==MAX : q==0).
  - tc does not depend on en; for cascading, the next stage's cin = this stage's tc & en.
  - Chaining N stages with MAX = 9 gives an N-digit BCD counter.
- wrap ← 1 on the edge that performs an end event (in either mode), otherwise 0.
- ovf:
  - Set on the edge that performs an end event.
  - Cleared on an edge with ovf_clr = 1 and no end event.
  - Set and clear on the same edge: set wins.
- Changing up_dn mid-count takes effect on the next edge with no glitch state.
- Arithmetic is WIDTH bits, compared against MAX. Values above MAX are only reachable through a clamped load, so they never appear on q.

## Timing
- q, wrap and ovf change only on the rising clk edge, or asynchronously on reset assertion.
- Latency:
  - load → q: 1 cycle.
  - Count enable → q change: 1 cycle.
  - End event → wrap/ovf: visible the same cycle q shows the wrapped or held value.
- tc is combinational from q, cin and up_dn, with no register stage. A cascade of N stages adds N AND levels to the critical path.
- wrap is high for exactly one cycle per end event. Back-to-back end events (saturate mode held at an end with en = 1) keep wrap high on consecutive cycles.
- Reset asserted mid-count or mid-load: the in-flight operation is discarded and q = 0 immediately.

## Test plan
- WIDTH=4, MAX=9, SATURATE=0, up, en=cin=1 for 12 cycles from reset → q sequence 1..9,0,1,2; wrap high only in the cycle q=0; ovf=1 from that cycle; tc=1 while q=9.
- Same configuration, down from q=0 → q = 9,8,7; wrap pulses on the 9; pulse ovf_clr together with an end event → ovf stays 1; ovf_clr alone → ovf=0 next cycle.
- SATURATE=1, MAX=9, up from load_val=7 → q = 7,8,9,9,9; wrap high on each edge at 9 after the first arrival; down from load 1 → q = 0,0.
- load=1 with load_val=13, MAX=9, en=1 on the same edge → q=9, no wrap, no ovf; load with en=0 still loads.
- Two stages, MAX=9, the high stage's cin = low tc & en, count 0→23 → {hi,lo} goes 0,0 … 0,9 → 1,0 … 2,3; the high stage advances only on the low stage's 9→0.
- Assert reset_outer low between clock edges while q=6 → q=0 and ovf=0 with no clock edge; hold reset across edges → q stays 0; release → counting resumes from 1 on the next edge.
